// File: rtl/serial_xor_frame_checker.sv
// Serial XOR frame checker: folds x^y bit pairs into FRAME_LEN-bit frames and
// reports the difference vector, its popcount and parity over valid/ready handshakes.
module serial_xor_frame_checker #(
    parameter int  FRAME_LEN = 8,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 x,
    input  logic                 y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_LEN-1:0] out_diff,
    output logic [CW-1:0]        out_count,
    output logic                 out_parity
);

    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    if (FRAME_LEN < 1 || FRAME_LEN > 32) begin : g_len_check
        $error("serial_xor_frame_checker: FRAME_LEN must be in 1..32");
    end

    typedef enum logic {COLLECT, DONE} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [FRAME_LEN-1:0] diff_q, diff_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 parity_q, parity_d;
    logic                 d;

    assign d = x ^ y;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        diff_d    = diff_q;
        count_d   = count_q;
        parity_d  = parity_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Shift-left form keeps FRAME_LEN=1 legal: the old bit falls off.
                    diff_d   = (diff_q << 1) | FRAME_LEN'(d);
                    count_d  = count_q + CW'(d);
                    parity_d = parity_q ^ d;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = COLLECT;
                    diff_d   = '0;
                    count_d  = '0;
                    parity_d = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= COLLECT;
            idx_q    <= '0;
            diff_q   <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            count_q  <= count_d;
            parity_q <= parity_d;
        end
    end

    assign out_diff   = diff_q;
    assign out_count  = count_q;
    assign out_parity = parity_q;

endmodule

// File: tb/tb_serial_xor_frame_checker.sv
// Scoreboard bench for serial_xor_frame_checker at FRAME_LEN 4, 1 and 32.
module tb_serial_xor_frame_checker;

    typedef struct packed {
        logic [31:0] diff;
        logic [5:0]  cnt;
        logic        par;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q4[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       in_valid4, in_ready4, x4, y4, out_valid4, out_ready4, out_parity4;
    logic [3:0] out_diff4;
    logic [2:0] out_count4;

    logic       in_valid1, in_ready1, x1, y1, out_valid1, out_ready1, out_parity1;
    logic [0:0] out_diff1;
    logic [0:0] out_count1;

    logic        in_valid32, in_ready32, x32, y32, out_valid32, out_ready32, out_parity32;
    logic [31:0] out_diff32;
    logic [5:0]  out_count32;

    serial_xor_frame_checker #(.FRAME_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .x(x4), .y(y4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_diff(out_diff4), .out_count(out_count4), .out_parity(out_parity4)
    );

    serial_xor_frame_checker #(.FRAME_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .x(x1), .y(y1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_diff(out_diff1), .out_count(out_count1), .out_parity(out_parity1)
    );

    serial_xor_frame_checker #(.FRAME_LEN(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .x(x32), .y(y32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_diff(out_diff32), .out_count(out_count32), .out_parity(out_parity32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every completed handshake on the FRAME_LEN=4 instance.
    always @(negedge clk) begin
        res_t e;
        if (!reset && out_valid4 && out_ready4) begin
            check("frame_expected", 64'(q4.size() > 0), 64'(1));
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("sb_diff",   64'(out_diff4),   64'(e.diff));
                check("sb_count",  64'(out_count4),  64'(e.cnt));
                check("sb_parity", 64'(out_parity4), 64'(e.par));
            end
        end
    end

    logic counting = 1'b0;
    int   gap_cnt  = 0;
    always @(negedge clk) begin
        if (counting && !in_ready4) gap_cnt++;
    end

    task automatic send4(input logic xb, input logic yb, input int gap);
        int n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 64'(in_ready4), 64'(1));
        in_valid4 = 1'b1;
        x4 = xb;
        y4 = yb;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            x4 = 1'($urandom);
            y4 = 1'($urandom);
        end
    endtask

    // xs[3]/ys[3] is the first pair sent; the first bit lands in the MSB.
    task automatic send_frame4(input logic [3:0] xs, input logic [3:0] ys, input int gap);
        res_t e;
        logic [3:0] dv;
        dv     = xs ^ ys;
        e.diff = 32'(dv);
        e.cnt  = 6'($countones(dv));
        e.par  = ^dv;
        q4.push_back(e);
        for (int i = 3; i >= 0; i--) send4(xs[i], ys[i], (i > 0) ? gap : 0);
    endtask

    task automatic wait_idle4();
        int n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 64'(in_ready4), 64'(1));
    endtask

    initial begin
        logic [3:0]  xs, ys, hold_diff;
        logic [31:0] exp32;
        int          n;

        reset = 1'b1;
        {in_valid4, x4, y4, out_ready4}     = '0;
        {in_valid1, x1, y1, out_ready1}     = '0;
        {in_valid32, x32, y32, out_ready32} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid4),  64'(0));
        check("rst_out_diff",  64'(out_diff4),   64'(0));
        check("rst_out_count", 64'(out_count4),  64'(0));
        check("rst_out_par",   64'(out_parity4), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready4), 64'(1));

        // Test 1: back-to-back, single-cycle out_valid
        out_ready4 = 1'b1;
        send_frame4(4'b0011, 4'b0101, 0);
        @(negedge clk);
        check("t1_valid_rise", 64'(out_valid4), 64'(1));
        @(negedge clk);
        check("t1_valid_fall", 64'(out_valid4), 64'(0));

        // Test 2: backpressure, results held, junk inputs ignored
        out_ready4 = 1'b0;
        xs = 4'b1010;
        ys = 4'b0101;
        hold_diff = xs ^ ys;
        send_frame4(xs, ys, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t2_hold_valid", 64'(out_valid4), 64'(1));
            check("t2_in_ready",   64'(in_ready4),  64'(0));
            check("t2_hold_diff",  64'(out_diff4),  64'(hold_diff));
            check("t2_hold_count", 64'(out_count4), 64'($countones(hold_diff)));
            in_valid4 = 1'b1;
            x4 = 1'($urandom);
            y4 = 1'($urandom);
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_clr_valid", 64'(out_valid4),  64'(0));
        check("t2_clr_diff",  64'(out_diff4),   64'(0));
        check("t2_clr_count", 64'(out_count4),  64'(0));
        check("t2_clr_par",   64'(out_parity4), 64'(0));

        // Test 3: idle gaps between pairs
        send_frame4(4'b1110, 4'b1010, 2);
        wait_idle4();

        // Test 4: reset aborts a partial frame
        send4(1'b0, 1'b1, 0);
        send4(1'b0, 1'b1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_rst_valid", 64'(out_valid4), 64'(0));
        check("t4_rst_count", 64'(out_count4), 64'(0));
        send_frame4(4'b0000, 4'b0000, 0);
        wait_idle4();

        // Test 5: two back-to-back frames with one bubble
        gap_cnt  = 0;
        counting = 1'b1;
        send_frame4(4'($urandom), 4'($urandom), 0);
        send_frame4(4'($urandom), 4'($urandom), 0);
        counting = 1'b0;
        check("t5_bubble", 64'(gap_cnt), 64'(1));

        for (int f = 0; f < 6; f++) send_frame4(4'($urandom), 4'($urandom), int'($urandom_range(0, 1)));

        // FRAME_LEN=1
        @(negedge clk);
        check("fl1_in_ready", 64'(in_ready1), 64'(1));
        in_valid1 = 1'b1;
        x1 = 1'b1;
        y1 = 1'b0;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        check("fl1_valid",  64'(out_valid1),  64'(1));
        check("fl1_diff",   64'(out_diff1),   64'(1));
        check("fl1_count",  64'(out_count1),  64'(1));
        check("fl1_parity", 64'(out_parity1), 64'(1));
        out_ready1 = 1'b1;
        @(negedge clk);
        check("fl1_valid_fall", 64'(out_valid1), 64'(0));

        // FRAME_LEN=32, all-mismatch frame
        exp32 = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            in_valid32 = 1'b1;
            x32 = 1'($urandom);
            y32 = ~x32;
            exp32 = {exp32[30:0], x32 ^ y32};
            @(posedge clk);
            #1;
            in_valid32 = 1'b0;
        end
        @(negedge clk);
        check("fl32_valid",  64'(out_valid32),  64'(1));
        check("fl32_diff",   64'(out_diff32),   64'(exp32));
        check("fl32_count",  64'(out_count32),  64'($countones(exp32)));
        check("fl32_parity", 64'(out_parity32), 64'(^exp32));
        out_ready32 = 1'b1;
        @(negedge clk);
        check("fl32_valid_fall", 64'(out_valid32), 64'(0));

        n = 0;
        while (q4.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 64'(q4.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
